// File: rtl/apb2axi_rsp_collector.sv
// AXI R-channel collector: pushes beats to the data FIFO and one completion per burst.
// Latency: accepted beat visible on dat_vld next cycle; completion follows the last dat handshake.
// Backpressure: 2-entry skid; rready drops when skid is full or a completion is pending.
// Option APB2AXI_RSP_PARITY_EN prepends an even-parity bit to dat_data.
module apb2axi_rsp_collector #(
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int MAX_BEATS = 16
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic                                   rvalid,
    output logic                                   rready,
    input  logic [DATA_W-1:0]                      rdata,
    input  logic [1:0]                             rresp,
    input  logic                                   rlast,
    input  logic [ID_W-1:0]                        rid,
    output logic                                   dat_vld,
    input  logic                                   dat_rdy,
`ifdef APB2AXI_RSP_PARITY_EN
    output logic [DATA_W+2:0]                      dat_data,
`else
    output logic [DATA_W+1:0]                      dat_data,
`endif
    output logic                                   cpl_vld,
    input  logic                                   cpl_rdy,
    output logic [ID_W+$clog2(MAX_BEATS+1)+3:0]    cpl_data,
    output logic [1:0]                             err_sticky
);
    localparam int CNT_W = $clog2(MAX_BEATS+1);
`ifdef APB2AXI_RSP_PARITY_EN
    localparam int DW = DATA_W + 3;
`else
    localparam int DW = DATA_W + 2;
`endif

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, CPL_WAIT} state_t;

    state_t            state;
    logic              rdy_en;
    logic [ID_W-1:0]   id;
    logic [CNT_W-1:0]  beat_cnt;
    logic [1:0]        resp_acc;
    logic              err_id, err_ovr;
    logic              err_id_seen, err_ovr_seen;
    logic [DW-1:0]     skid_head, skid_tail;
    logic [1:0]        skid_cnt;
    logic [DW-1:0]     beat_dat;
    logic              accept, push, pop;

    // Severity rank: EXOKAY lowest, then OKAY, SLVERR, DECERR.
    function automatic logic [1:0] sev(input logic [1:0] r);
        case (r)
            2'd0:    sev = 2'd1;
            2'd1:    sev = 2'd0;
            default: sev = r;
        endcase
    endfunction

    function automatic logic [1:0] merge(input logic [1:0] a, input logic [1:0] b);
        merge = (sev(b) > sev(a)) ? b : a;
    endfunction

`ifdef APB2AXI_RSP_PARITY_EN
    assign beat_dat = {^{rresp, rdata}, rresp, rdata};
`else
    assign beat_dat = {rresp, rdata};
`endif

    assign rready     = rdy_en && (skid_cnt != 2'd2) && (state != CPL_WAIT);
    assign accept     = rvalid && rready;
    assign push       = accept && (state != DRAIN);
    assign pop        = dat_vld && dat_rdy;
    assign dat_vld    = (skid_cnt != 2'd0);
    assign dat_data   = skid_head;
    assign err_sticky = {err_id_seen, err_ovr_seen};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            skid_head <= '0;
            skid_tail <= '0;
            skid_cnt  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (skid_cnt == 2'd0) skid_head <= beat_dat;
                    else                  skid_tail <= beat_dat;
                    skid_cnt <= skid_cnt + 2'd1;
                end
                2'b01: begin
                    skid_head <= skid_tail;
                    skid_cnt  <= skid_cnt - 2'd1;
                end
                2'b11: begin
                    if (skid_cnt == 2'd1) begin
                        skid_head <= beat_dat;
                    end else begin
                        skid_head <= skid_tail;
                        skid_tail <= beat_dat;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            rdy_en       <= 1'b0;
            id           <= '0;
            beat_cnt     <= '0;
            resp_acc     <= 2'd0;
            err_id       <= 1'b0;
            err_ovr      <= 1'b0;
            err_id_seen  <= 1'b0;
            err_ovr_seen <= 1'b0;
            cpl_vld      <= 1'b0;
            cpl_data     <= '0;
        end else begin
            rdy_en <= 1'b1;
            case (state)
                IDLE: if (accept) begin
                    id       <= rid;
                    beat_cnt <= CNT_W'(1);
                    resp_acc <= rresp;
                    err_id   <= 1'b0;
                    err_ovr  <= 1'b0;
                    state    <= rlast ? CPL_WAIT : COLLECT;
                end
                COLLECT: if (accept) begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                    resp_acc <= merge(resp_acc, rresp);
                    if (rid != id) begin
                        err_id      <= 1'b1;
                        err_id_seen <= 1'b1;
                    end
                    if (rlast) begin
                        state <= CPL_WAIT;
                    end else if (beat_cnt == CNT_W'(MAX_BEATS-1)) begin
                        err_ovr      <= 1'b1;
                        err_ovr_seen <= 1'b1;
                        state        <= DRAIN;
                    end
                end
                // Overflowed burst: swallow the tail so the slave can finish it.
                DRAIN: if (accept) begin
                    if (rid != id) begin
                        err_id      <= 1'b1;
                        err_id_seen <= 1'b1;
                    end
                    if (rlast) state <= CPL_WAIT;
                end
                CPL_WAIT: begin
                    if (cpl_vld) begin
                        if (cpl_rdy) begin
                            cpl_vld  <= 1'b0;
                            state    <= IDLE;
                            id       <= '0;
                            beat_cnt <= '0;
                            resp_acc <= 2'd0;
                            err_id   <= 1'b0;
                            err_ovr  <= 1'b0;
                        end
                    end else if (skid_cnt == 2'd0) begin
                        cpl_vld  <= 1'b1;
                        cpl_data <= {id, beat_cnt, resp_acc, err_id, err_ovr};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb2axi_rsp_collector.sv
// Randomized and directed stimulus for apb2axi_rsp_collector against a burst-level reference model.
module tb_apb2axi_rsp_collector;
    localparam int DATA_W    = 32;
    localparam int ID_W      = 4;
    localparam int MAX_BEATS = 16;
    localparam int CNT_W     = $clog2(MAX_BEATS+1);
`ifdef APB2AXI_RSP_PARITY_EN
    localparam int DW = DATA_W + 3;
`else
    localparam int DW = DATA_W + 2;
`endif
    localparam int CPW = ID_W + CNT_W + 4;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
        logic [ID_W-1:0]   id;
    } beat_t;

    logic              clk = 1'b0;
    logic              resetn;
    logic              rvalid, rready, rlast, dat_vld, dat_rdy, cpl_vld, cpl_rdy;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic [ID_W-1:0]   rid;
    logic [DW-1:0]     dat_data;
    logic [CPW-1:0]    cpl_data;
    logic [1:0]        err_sticky;

    apb2axi_rsp_collector #(.DATA_W(DATA_W), .ID_W(ID_W), .MAX_BEATS(MAX_BEATS)) dut (
        .clk(clk), .resetn(resetn),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid),
        .dat_vld(dat_vld), .dat_rdy(dat_rdy), .dat_data(dat_data),
        .cpl_vld(cpl_vld), .cpl_rdy(cpl_rdy), .cpl_data(cpl_data),
        .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Stimulus and expectation queues
    beat_t          tx[$];
    logic [DW-1:0]  exp_dat[$];
    logic [CPW-1:0] exp_cpl[$];
    logic [CPW-1:0] last_cpl;
    bit             taken = 0;
    bit             dat_hold = 0;
    int             vld_pct = 100, drdy_pct = 100, crdy_pct = 100;
    int             n_acc = 0, n_dat_hs = 0, n_cpl_hs = 0;

    // Burst-level reference model
    bit              m_busy = 0;
    logic [ID_W-1:0] m_id;
    int              m_cnt;
    logic [1:0]      m_resp;
    bit              m_eid, m_eovr;
    bit              st_id = 0, st_ovr = 0;
    int              rank_tbl [4] = '{1, 0, 2, 3};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pack_dat(input beat_t b);
`ifdef APB2AXI_RSP_PARITY_EN
        return {^{b.resp, b.data}, b.resp, b.data};
`else
        return {b.resp, b.data};
`endif
    endfunction

    task automatic model_beat(input beat_t b);
        if (!m_busy) begin
            m_busy = 1; m_id = b.id; m_cnt = 1; m_resp = b.resp; m_eid = 0; m_eovr = 0;
            exp_dat.push_back(pack_dat(b));
        end else begin
            if (b.id != m_id) begin m_eid = 1; st_id = 1; end
            if (m_cnt < MAX_BEATS) begin
                m_cnt++;
                if (rank_tbl[b.resp] > rank_tbl[m_resp]) m_resp = b.resp;
                exp_dat.push_back(pack_dat(b));
            end else begin
                m_eovr = 1; st_ovr = 1;
            end
        end
        if (b.last) begin
            exp_cpl.push_back({m_id, CNT_W'(m_cnt), m_resp, m_eid, m_eovr});
            m_busy = 0;
        end
    endtask

    task automatic push_beat(input logic [DATA_W-1:0] d, input logic [1:0] r, input logic l, input logic [ID_W-1:0] i);
        beat_t b;
        b.data = d; b.resp = r; b.last = l; b.id = i;
        tx.push_back(b);
    endtask

    task automatic cycle();
        @(negedge clk);
        if (taken) begin rvalid = 1'b0; taken = 0; end
        if (!rvalid && tx.size() > 0 && $urandom_range(99) < vld_pct) begin
            rvalid = 1'b1; rdata = tx[0].data; rresp = tx[0].resp; rlast = tx[0].last; rid = tx[0].id;
        end
        dat_rdy = !dat_hold && ($urandom_range(99) < drdy_pct);
        cpl_rdy = ($urandom_range(99) < crdy_pct);
        #1;
        if (exp_cpl.size() > 0) chk("rready_while_cpl_pending", 64'(rready), 64'(0));
        if (cpl_vld) chk("cpl_before_data_drained", 64'(exp_dat.size()), 64'(0));
        if (dat_vld && dat_rdy) begin
            chk("dat_push_expected", 64'(exp_dat.size() != 0), 64'(1));
            if (exp_dat.size() != 0) begin
                chk("dat_data", 64'(dat_data), 64'(exp_dat[0]));
                void'(exp_dat.pop_front());
            end
            n_dat_hs++;
        end
        if (cpl_vld && cpl_rdy) begin
            chk("cpl_push_expected", 64'(exp_cpl.size() != 0), 64'(1));
            if (exp_cpl.size() != 0) begin
                chk("cpl_data", 64'(cpl_data), 64'(exp_cpl[0]));
                void'(exp_cpl.pop_front());
            end
            last_cpl = cpl_data;
            n_cpl_hs++;
        end
        if (rvalid && rready) begin
            model_beat(tx[0]);
            void'(tx.pop_front());
            taken = 1;
            n_acc++;
        end
        @(posedge clk);
    endtask

    task automatic run_until_idle(input int budget);
        bit done = 0;
        for (int i = 0; i < budget; i++) begin
            if (tx.size() == 0 && !rvalid && exp_dat.size() == 0 && exp_cpl.size() == 0 && !m_busy) begin
                done = 1;
                break;
            end
            cycle();
        end
        chk("idle_within_budget", 64'(done), 64'(1));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rready"},   64'(rready),     64'(0));
        chk({tag, "_dat_vld"},  64'(dat_vld),    64'(0));
        chk({tag, "_cpl_vld"},  64'(cpl_vld),    64'(0));
        chk({tag, "_dat_data"}, 64'(dat_data),   64'(0));
        chk({tag, "_cpl_data"}, 64'(cpl_data),   64'(0));
        chk({tag, "_sticky"},   64'(err_sticky), 64'(0));
    endtask

    initial begin
        int a0, d0, k;
        beat_t b1;
        logic [ID_W-1:0] bid;

        resetn = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'd0; rlast = 1'b0; rid = '0;
        dat_rdy = 1'b0; cpl_rdy = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk_reset_outputs("reset");
        @(negedge clk) resetn = 1'b1;

        // Single beat
        push_beat(32'hA5A5_0001, 2'd0, 1'b1, 4'd3);
        b1 = tx[0];
        a0 = n_acc; k = 0;
        while (n_acc == a0 && k < 20) begin cycle(); k++; end
        #1;
        chk("t1_dat_vld_next_cycle", 64'(dat_vld), 64'(1));
        chk("t1_dat_data", 64'(dat_data), 64'(pack_dat(b1)));
        run_until_idle(50);
        chk("t1_cpl", 64'(last_cpl), 64'({4'd3, CNT_W'(1), 2'd0, 1'b0, 1'b0}));

        // Four beats with mixed responses
        d0 = n_dat_hs;
        push_beat(32'h1111_0000, 2'd0, 1'b0, 4'd7);
        push_beat(32'h1111_0001, 2'd1, 1'b0, 4'd7);
        push_beat(32'h1111_0002, 2'd2, 1'b0, 4'd7);
        push_beat(32'h1111_0003, 2'd0, 1'b1, 4'd7);
        run_until_idle(100);
        chk("t2_dat_pushes", 64'(n_dat_hs - d0), 64'(4));
        chk("t2_cpl", 64'(last_cpl), 64'({4'd7, CNT_W'(4), 2'd2, 1'b0, 1'b0}));

        // Eight beats with a downstream stall mid-burst
        d0 = n_dat_hs;
        for (int i = 0; i < 8; i++) push_beat($urandom, 2'(i % 3 == 1), i == 7, 4'd9);
        a0 = n_acc; k = 0;
        while (n_acc - a0 < 3 && k < 50) begin cycle(); k++; end
        dat_hold = 1;
        a0 = n_acc;
        repeat (5) cycle();
        chk("t3_beats_accepted_while_stalled_le2", 64'(n_acc - a0 <= 2), 64'(1));
        dat_hold = 0;
        run_until_idle(200);
        chk("t3_dat_pushes", 64'(n_dat_hs - d0), 64'(8));
        chk("t3_cpl_cnt", 64'(last_cpl[CNT_W+3:4]), 64'(8));

        // Overlong burst: 20 beats against a 16-beat limit
        d0 = n_dat_hs; a0 = n_cpl_hs;
        drdy_pct = 70;
        for (int i = 0; i < 20; i++) push_beat(32'hBEEF_0000 + i, 2'd0, i == 19, 4'd1);
        run_until_idle(400);
        chk("t4_dat_pushes", 64'(n_dat_hs - d0), 64'(16));
        chk("t4_one_completion", 64'(n_cpl_hs - a0), 64'(1));
        chk("t4_cpl", 64'(last_cpl), 64'({4'd1, CNT_W'(16), 2'd0, 1'b0, 1'b1}));
        chk("t4_sticky_ovr", 64'(err_sticky[0]), 64'(1));

        // ID mismatch on beat 2
        push_beat(32'h2, 2'd0, 1'b0, 4'd2);
        push_beat(32'h3, 2'd0, 1'b0, 4'd5);
        push_beat(32'h4, 2'd0, 1'b1, 4'd2);
        run_until_idle(100);
        chk("t5_cpl", 64'(last_cpl), 64'({4'd2, CNT_W'(3), 2'd0, 1'b1, 1'b0}));
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < 4; i++) push_beat($urandom, 2'd0, i == 3, 4'd6);
        run_until_idle(300);
        chk("t5_sticky_id_persists", 64'(err_sticky[1]), 64'(1));

        // Randomized bursts
        for (int b = 0; b < 25; b++) begin
            int n;
            n = $urandom_range(1, MAX_BEATS + 3);
            bid = ID_W'($urandom);
            vld_pct = $urandom_range(40, 100);
            drdy_pct = $urandom_range(30, 100);
            crdy_pct = $urandom_range(30, 100);
            for (int i = 0; i < n; i++)
                push_beat($urandom, 2'($urandom_range(0, 3)), i == n - 1,
                          ($urandom_range(99) < 8) ? ID_W'($urandom) : bid);
            run_until_idle(600);
        end
        chk("rand_sticky", 64'(err_sticky), 64'({st_id, st_ovr}));

        // Reset during beat 3 of a 6-beat burst
        vld_pct = 100; drdy_pct = 100; crdy_pct = 100;
        for (int i = 0; i < 6; i++) push_beat($urandom, 2'd2, i == 5, 4'd4);
        a0 = n_acc; k = 0;
        while (n_acc - a0 < 2 && k < 50) begin cycle(); k++; end
        @(negedge clk);
        resetn = 1'b0;
        #1 chk_reset_outputs("midreset");
        rvalid = 1'b0; taken = 0;
        tx.delete(); exp_dat.delete(); exp_cpl.delete();
        m_busy = 0; st_id = 0; st_ovr = 0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        d0 = n_dat_hs;
        for (int i = 0; i < 3; i++) push_beat(32'hC0DE_0000 + i, 2'd0, i == 2, 4'd8);
        run_until_idle(100);
        chk("t6_dat_pushes", 64'(n_dat_hs - d0), 64'(3));
        chk("t6_cpl", 64'(last_cpl), 64'({4'd8, CNT_W'(3), 2'd0, 1'b0, 1'b0}));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
